// File: rtl/intr_ctx_ctrl_if.sv
// intr_ctx_ctrl_if: interrupt device <-> core handshake (request, vector, enable, retire pulse)
interface intr_ctx_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              intr_jmp;
    logic [ADDR_W-1:0] intr_jmp_addr;
    logic              intr_en;
    logic              eret_clear_en;
    modport master (output intr_jmp, output intr_jmp_addr, input intr_en, input eret_clear_en);
    modport slave (input intr_jmp, input intr_jmp_addr, output intr_en, output eret_clear_en);
endinterface

// File: rtl/intr_ctx_ctrl.sv
// intr_ctx_ctrl: interrupt entry/return sequencer with EPC save and post-ERET guard window
module intr_ctx_ctrl #(
    parameter int ADDR_W    = 10,
    parameter int GUARD_CYC = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    intr_ctx_ctrl_if.slave    dev,
    input  logic [ADDR_W-1:0] pc_next,
    input  logic              stall,
    input  logic              is_eret,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_addr,
    output logic              intr_active,
    output logic [ADDR_W-1:0] epc,
    output logic [CNT_W-1:0]  intr_cnt,
    output logic              err_eret
);
    localparam logic [3:0] G_LOAD = 4'(GUARD_CYC == 0 ? 0 : GUARD_CYC - 1);
    typedef enum logic [1:0] {IDLE, SERVICE, GUARD} state_t;
    state_t     state, state_n;
    logic [3:0] gcnt, gcnt_n;
    logic       take, ret, spur;

    always_comb begin
        take = !rst && state == IDLE && dev.intr_jmp && !stall;
        ret = !rst && state == SERVICE && is_eret && !stall;
        // entry wins over a same-cycle ERET in IDLE, so that case is not flagged
        spur = state != SERVICE && is_eret && !stall && !take;
        state_n = state;
        gcnt_n = gcnt;
        if (take) state_n = SERVICE;
        else if (ret) begin
            state_n = GUARD_CYC == 0 ? IDLE : GUARD;
            gcnt_n = G_LOAD;
        end else if (state == GUARD) begin
            state_n = gcnt == 4'd0 ? IDLE : GUARD;
            gcnt_n = gcnt - 4'(gcnt != 4'd0);
        end
        dev.intr_en = rst || state == IDLE;
        dev.eret_clear_en = ret;
        redirect_valid = take || ret;
        redirect_addr = take ? dev.intr_jmp_addr : ret ? epc : '0;
        intr_active = state == SERVICE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gcnt <= '0;
            epc <= '0;
            intr_cnt <= '0;
            err_eret <= 1'b0;
        end else begin
            state <= state_n;
            gcnt <= gcnt_n;
            if (take) begin
                epc <= pc_next;
                intr_cnt <= intr_cnt + 1'b1;
            end
            if (spur) err_eret <= 1'b1;
        end
    end
endmodule

// File: tb/tb_intr_ctx_ctrl.sv
// tb_intr_ctx_ctrl: directed vector table plus randomized run against a behavioural model
module tb_intr_ctx_ctrl;
    localparam int AW = 10;
    localparam int GC = 2;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst, stall, is_eret;
    logic [AW-1:0] pc_next;
    logic          redirect_valid, intr_active, err_eret;
    logic [AW-1:0] redirect_addr, epc;
    logic [CW-1:0] intr_cnt;
    int            total = 0;
    int            bad = 0;

    intr_ctx_ctrl_if #(.ADDR_W(AW)) bus ();

    intr_ctx_ctrl #(.ADDR_W(AW), .GUARD_CYC(GC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .dev(bus.slave), .pc_next(pc_next), .stall(stall),
        .is_eret(is_eret), .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .intr_active(intr_active), .epc(epc), .intr_cnt(intr_cnt), .err_eret(err_eret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst, jmp; logic [AW-1:0] ja, pc; logic st, er;
        logic rv; logic [AW-1:0] ra; logic clr, en, act; logic [AW-1:0] epc;
        logic [CW-1:0] cnt; logic err, regs;
    } vec_t;
    vec_t vt[$];

    task automatic cmp(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endtask

    task automatic drive(input logic r, input logic j, input logic [AW-1:0] ja,
                         input logic [AW-1:0] pc, input logic st, input logic er);
        rst = r; bus.intr_jmp = j; bus.intr_jmp_addr = ja; pc_next = pc; stall = st; is_eret = er;
    endtask

    // model: handler flag, remaining guard cycles, saved pc, taken count, sticky error
    bit            m_in, m_err, m_take, m_ret, prev_clr;
    int            m_gl, m_cnt;
    logic [AW-1:0] m_epc, m_ra;

    initial begin
        //              rst j  ja      pc      st er   rv ra      clr en act epc     cnt err regs
        vt.push_back('{1, 0, 10'h0,  10'h0,  0, 0,   0, 10'h0,  0, 1, 0, 10'h0,  0, 0, 0});
        vt.push_back('{1, 0, 10'h0,  10'h0,  0, 0,   0, 10'h0,  0, 1, 0, 10'h0,  0, 0, 1});
        vt.push_back('{0, 0, 10'h0,  10'h0,  0, 0,   0, 10'h0,  0, 1, 0, 10'h0,  0, 0, 1});
        vt.push_back('{0, 1, 10'h208,10'h123,0, 0,   1, 10'h208,0, 1, 0, 10'h0,  0, 0, 1});
        vt.push_back('{0, 1, 10'h208,10'h124,0, 0,   0, 10'h0,  0, 0, 1, 10'h123,1, 0, 1});
        vt.push_back('{0, 1, 10'h208,10'h124,0, 1,   1, 10'h123,1, 0, 1, 10'h123,1, 0, 1});
        vt.push_back('{0, 1, 10'h208,10'h125,0, 0,   0, 10'h0,  0, 0, 0, 10'h123,1, 0, 1});
        vt.push_back('{0, 1, 10'h208,10'h125,0, 0,   0, 10'h0,  0, 0, 0, 10'h123,1, 0, 1});
        for (int i = 0; i < 3; i++)
            vt.push_back('{0, 1, 10'h300,10'h040,1, 0,   0, 10'h0,  0, 1, 0, 10'h123,1, 0, 1});
        vt.push_back('{0, 1, 10'h300,10'h050,0, 0,   1, 10'h300,0, 1, 0, 10'h123,1, 0, 1});
        vt.push_back('{0, 0, 10'h0,  10'h0,  1, 1,   0, 10'h0,  0, 0, 1, 10'h050,2, 0, 1});
        vt.push_back('{0, 0, 10'h0,  10'h0,  0, 1,   1, 10'h050,1, 0, 1, 10'h050,2, 0, 1});
        vt.push_back('{0, 0, 10'h0,  10'h0,  0, 1,   0, 10'h0,  0, 0, 0, 10'h050,2, 0, 1});
        vt.push_back('{0, 0, 10'h0,  10'h0,  0, 0,   0, 10'h0,  0, 0, 0, 10'h050,2, 1, 1});
        vt.push_back('{0, 0, 10'h0,  10'h0,  0, 1,   0, 10'h0,  0, 1, 0, 10'h050,2, 1, 1});
        vt.push_back('{0, 1, 10'h010,10'h003,0, 0,   1, 10'h010,0, 1, 0, 10'h050,2, 1, 1});
        vt.push_back('{0, 0, 10'h0,  10'h0,  0, 1,   1, 10'h003,1, 0, 1, 10'h003,3, 1, 1});
        vt.push_back('{0, 0, 10'h0,  10'h0,  0, 0,   0, 10'h0,  0, 0, 0, 10'h003,3, 1, 1});
        vt.push_back('{0, 0, 10'h0,  10'h0,  0, 0,   0, 10'h0,  0, 0, 0, 10'h003,3, 1, 1});
        vt.push_back('{0, 1, 10'h020,10'h007,0, 0,   1, 10'h020,0, 1, 0, 10'h003,3, 1, 1});
        vt.push_back('{1, 0, 10'h0,  10'h0,  0, 1,   0, 10'h0,  0, 1, 1, 10'h007,0, 1, 1});
        vt.push_back('{0, 0, 10'h0,  10'h0,  0, 0,   0, 10'h0,  0, 1, 0, 10'h0,  0, 0, 1});

        drive(1, 0, '0, '0, 0, 0);
        #1;
        foreach (vt[i]) begin
            drive(vt[i].rst, vt[i].jmp, vt[i].ja, vt[i].pc, vt[i].st, vt[i].er);
            @(negedge clk);
            cmp($sformatf("row%0d redirect_valid", i), 32'(redirect_valid), 32'(vt[i].rv));
            cmp($sformatf("row%0d redirect_addr", i), 32'(redirect_addr), 32'(vt[i].ra));
            cmp($sformatf("row%0d eret_clear_en", i), 32'(bus.eret_clear_en), 32'(vt[i].clr));
            cmp($sformatf("row%0d intr_en", i), 32'(bus.intr_en), 32'(vt[i].en));
            if (vt[i].regs) begin
                cmp($sformatf("row%0d intr_active", i), 32'(intr_active), 32'(vt[i].act));
                cmp($sformatf("row%0d epc", i), 32'(epc), 32'(vt[i].epc));
                cmp($sformatf("row%0d intr_cnt", i), 32'(intr_cnt), 32'(vt[i].cnt));
                cmp($sformatf("row%0d err_eret", i), 32'(err_eret), 32'(vt[i].err));
            end
            @(posedge clk);
            #1;
        end

        // entry and ERET in the same IDLE cycle: entry wins, no error
        drive(0, 1, 10'h155, 10'h2aa, 0, 1);
        @(negedge clk);
        cmp("prec redirect_addr", 32'(redirect_addr), 32'h155);
        cmp("prec eret_clear_en", 32'(bus.eret_clear_en), 32'h0);
        @(posedge clk);
        #1;
        drive(0, 1, 10'h155, 10'h0, 0, 0);
        @(negedge clk);
        cmp("prec err_eret", 32'(err_eret), 32'h0);
        cmp("prec epc", 32'(epc), 32'h2aa);
        cmp("prec intr_active", 32'(intr_active), 32'h1);
        @(posedge clk);
        #1;

        prev_clr = 0;
        for (int c = 0; c < 3000; c++) begin
            drive(c == 0 || $urandom_range(63) == 0, $urandom_range(1), AW'($urandom), AW'($urandom),
                  $urandom_range(3) == 0, $urandom_range(9) < 3);
            @(negedge clk);
            if (c > 0) begin
                m_take = !rst && !m_in && m_gl == 0 && bus.intr_jmp && !stall;
                m_ret = !rst && m_in && is_eret && !stall;
                m_ra = m_take ? bus.intr_jmp_addr : m_ret ? m_epc : '0;
                cmp("rnd redirect_valid", 32'(redirect_valid), 32'(m_take || m_ret));
                cmp("rnd redirect_addr", 32'(redirect_addr), 32'(m_ra));
                cmp("rnd eret_clear_en", 32'(bus.eret_clear_en), 32'(m_ret));
                cmp("rnd clear_pulse_width", 32'(prev_clr && bus.eret_clear_en), 32'h0);
                cmp("rnd intr_en", 32'(bus.intr_en), 32'(rst || (!m_in && m_gl == 0)));
                cmp("rnd intr_active", 32'(intr_active), 32'(m_in));
                cmp("rnd epc", 32'(epc), 32'(m_epc));
                cmp("rnd intr_cnt", 32'(intr_cnt), 32'(m_cnt));
                cmp("rnd err_eret", 32'(err_eret), 32'(m_err));
            end
            prev_clr = bus.eret_clear_en;
            @(posedge clk);
            if (rst) begin
                m_in = 0; m_gl = 0; m_epc = '0; m_cnt = 0; m_err = 0;
            end else begin
                m_take = !m_in && m_gl == 0 && bus.intr_jmp && !stall;
                m_ret = m_in && is_eret && !stall;
                if (is_eret && !stall && !m_in && !m_take) m_err = 1;
                if (m_take) begin
                    m_in = 1; m_epc = pc_next; m_cnt = (m_cnt + 1) % (1 << CW);
                end else if (m_ret) begin
                    m_in = 0; m_gl = GC;
                end else if (m_gl > 0) m_gl--;
            end
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/intr_ctx_ctrl.md
Name: intr_ctx_ctrl

Overview:
Core-side responder to the synchronous interrupt device. It accepts the device's interrupt-jump request, saves the return PC (EPC), and redirects fetch to the vector. It masks further interrupts while a handler runs. On ERET it restores the PC, pulses eret_clear_en back to the device to retire the serviced request, and holds a guard window before re-enabling interrupts.

Parameters:
ADDR_W, 10, instruction-memory word-address width; matches IM_ADDR_BIT.
GUARD_CYC, 1, cycles intr_en stays low after ERET (0..15). 0 returns directly to IDLE.
CNT_W, 16, width of the interrupts-taken counter.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst  in  1  synchronous reset, active-high.
intr_jmp  in  1  interrupt-jump request from the interrupt device.
intr_jmp_addr  in  ADDR_W  vector address from the interrupt device.
pc_next  in  ADDR_W  address of the next instruction the core would execute; becomes EPC.
stall  in  1  pipeline stall. No entry or return is accepted while high.
is_eret  in  1  ERET instruction at the commit point this cycle.
intr_en  out  1  interrupt enable to the device.
redirect_valid  out  1  fetch redirect this cycle (combinational).
redirect_addr  out  ADDR_W  redirect target; 0 when redirect_valid=0.
eret_clear_en  out  1  one-cycle pulse to the device; clears the serviced request.
intr_active  out  1  handler in progress (state SERVICE).
epc  out  ADDR_W  saved return address.
intr_cnt  out  CNT_W  count of accepted interrupt entries; wraps.
err_eret  out  1  sticky flag: ERET accepted outside SERVICE.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, epc=0, intr_cnt=0, err_eret=0, guard counter=0. Outputs that cycle: intr_en=1, redirect_valid=0, eret_clear_en=0. Reset overrides every concurrent event, including mid-handler and mid-guard.
- States: IDLE, SERVICE, GUARD.
- intr_en=1 only in IDLE. intr_active=1 only in SERVICE.
- Entry, IDLE with intr_jmp=1 and stall=0:
  - Same cycle: redirect_valid=1, redirect_addr=intr_jmp_addr.
  - At the edge: epc<=pc_next, intr_cnt<=intr_cnt+1 (mod 2^CNT_W), state<=SERVICE.
  - Zero-latency redirect.
- IDLE with intr_jmp=1 and stall=1: no action. Retried every cycle until stall drops; intr_jmp stays level-held by the device.
- Return, SERVICE with is_eret=1 and stall=0:
  - Same cycle: redirect_valid=1, redirect_addr=epc, eret_clear_en=1.
  - At the edge: if GUARD_CYC=0, state<=IDLE; otherwise state<=GUARD and guard counter<=GUARD_CYC-1.
- SERVICE ignores intr_jmp, which stays asserted because the device queue is not yet cleared.
- SERVICE with is_eret=1 and stall=1: no action; retried.
- GUARD: intr_en=0 and intr_jmp is ignored.
  - Counter decrements each cycle. When the counter is 0 at an edge, state<=IDLE.
  - GUARD lasts exactly GUARD_CYC cycles.
  - is_eret in GUARD is spurious: err_eret<=1, no redirect, no pulse.
- is_eret=1 and stall=0 in IDLE: err_eret<=1, no redirect, no eret_clear_en. Entry takes precedence when intr_jmp=1 in the same cycle.
- eret_clear_en is never high for two consecutive cycles and never high outside SERVICE.
- epc changes only on an accepted entry. Nesting is not supported.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then 0 -> intr_en=1, redirect_valid=0, epc=0, intr_cnt=0, err_eret=0.
- Basic entry: IDLE, pc_next=0x123, intr_jmp=1, intr_jmp_addr=0x208 -> same cycle redirect_valid=1, redirect_addr=0x208. Next cycle epc=0x123, intr_active=1, intr_en=0, intr_cnt=1.
- Stalled entry: intr_jmp=1 with stall=1 for 3 cycles, then stall=0 with pc_next=0x050 -> no redirect during the stall cycles; redirect on cycle 4; epc=0x050.
- Return and guard (GUARD_CYC=2): in SERVICE with epc=0x123, is_eret=1 and stall=0 -> redirect_addr=0x123 and eret_clear_en=1 for one cycle. Then intr_en=0 for exactly 2 cycles with intr_jmp held high and no redirect. intr_en=1 on the 3rd cycle.
- Spurious ERET: is_eret=1 in IDLE with intr_jmp=0 -> no redirect, eret_clear_en=0, err_eret=1 and it stays 1.
- Reset mid-handler plus counter wrap (CNT_W=2): take 4 interrupts -> intr_cnt=0. Assert rst while in SERVICE -> next cycle IDLE, intr_en=1, epc=0.
